// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Byte-stream writer that fills the CPU instruction/data RAM from a framed
//   byte stream, then releases the CPU from reset once the frame checksum
//   verifies.
//
//   Frame: HDR, BASE, CNT, CNT x {hi, lo}, ENTRY, CSUM
//   CSUM = XOR of every frame byte after HDR, up to and including ENTRY.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   in_byte is valid
//   in_byte     in   stream byte
//   in_ready    out  loader accepts a byte this cycle (low only in RUN)
//   ram_w_en    out  one-cycle RAM write strobe
//   ram_w_addr  out  RAM write word address
//   ram_w_data  out  RAM write data, high byte first
//   start_pc    out  CPU start address (ENTRY byte)
//   cpu_rst_n   out  active-low CPU reset; 0 holds the CPU
//   done        out  program loaded and CPU released
//   err         out  last frame failed its checksum
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 16,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic [ADDR_W-1:0] start_pc,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_COUNT   = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_ENTRY   = 3'd5;
  localparam logic [2:0] S_CSUM    = 3'd6;
  localparam logic [2:0] S_RUN     = 3'd7;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_rem;
  logic [7:0]        r_hi;
  logic [7:0]        r_csum;
  logic              r_ram_w_en;
  logic [ADDR_W-1:0] r_ram_w_addr;
  logic [DATA_W-1:0] r_ram_w_data;
  logic [ADDR_W-1:0] r_start_pc;
  logic              r_cpu_rst_n;
  logic              r_done;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic [7:0]        w_csum_next;

  assign w_ready     = (r_state != S_RUN);
  assign w_accept    = in_valid && w_ready;
  assign w_csum_next = r_csum ^ in_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_rem        <= '0;
      r_hi         <= '0;
      r_csum       <= '0;
      r_ram_w_en   <= 1'b0;
      r_ram_w_addr <= '0;
      r_ram_w_data <= '0;
      r_start_pc   <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Write strobe defaults low; only a DATA_LO acceptance raises it.
      r_ram_w_en <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            // Non-header bytes are dropped while hunting for a frame.
            if (in_byte == HDR) begin
              r_state <= S_ADDR;
              r_csum  <= '0;
              r_err   <= 1'b0;
            end
          end
          S_ADDR: begin
            r_ptr   <= ADDR_W'(in_byte);
            r_csum  <= w_csum_next;
            r_state <= S_COUNT;
          end
          S_COUNT: begin
            r_rem   <= in_byte;
            r_csum  <= w_csum_next;
            r_state <= (in_byte == 8'd0) ? S_ENTRY : S_DATA_HI;
          end
          S_DATA_HI: begin
            r_hi    <= in_byte;
            r_csum  <= w_csum_next;
            r_state <= S_DATA_LO;
          end
          S_DATA_LO: begin
            r_ram_w_en   <= 1'b1;
            r_ram_w_addr <= r_ptr;
            r_ram_w_data <= DATA_W'({r_hi, in_byte});
            r_ptr        <= r_ptr + 1'b1;
            r_rem        <= r_rem - 8'd1;
            r_csum       <= w_csum_next;
            // r_rem still holds the pre-decrement count here.
            r_state      <= (r_rem == 8'd1) ? S_ENTRY : S_DATA_HI;
          end
          S_ENTRY: begin
            r_start_pc <= ADDR_W'(in_byte);
            r_csum     <= w_csum_next;
            r_state    <= S_CSUM;
          end
          S_CSUM: begin
            r_csum <= w_csum_next;
            // Running XOR equals the received CSUM byte on a good frame.
            if (r_csum == in_byte) begin
              r_state     <= S_RUN;
              r_cpu_rst_n <= 1'b1;
              r_done      <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign in_ready   = w_ready;
  assign ram_w_en   = r_ram_w_en;
  assign ram_w_addr = r_ram_w_addr;
  assign ram_w_data = r_ram_w_data;
  assign start_pc   = r_start_pc;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Directed self-checking bench for program_loader. Every RAM write strobe is
//   logged as {addr, data}; each scenario compares the log and the status
//   outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              ram_w_en;
  logic [ADDR_W-1:0] ram_w_addr;
  logic [DATA_W-1:0] ram_w_data;
  logic [ADDR_W-1:0] start_pc;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HDR(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .start_pc   (start_pc),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .err        (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] wlog[$];
  int          n_wide  = 0;
  logic        prev_en = 1'b0;
  logic [7:0]  fr[$];

  always @(negedge clk) begin
    if (ram_w_en === 1'b1) begin
      wlog.push_back({ram_w_addr, ram_w_data});
      if (prev_en === 1'b1) n_wide++;
    end
    prev_en = ram_w_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_byte  = '0;
  endtask

  // Sends fr[first..last] with `gap` idle cycles after each byte.
  task automatic send_range(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      send_byte(fr[i]);
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_byte  = '0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [23:0] log_at(input int idx);
    if (idx < wlog.size()) return wlog[idx];
    return 24'hxxxxxx;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),   32'd1);
    check({tag, "_wen"},       32'(ram_w_en),   32'd0);
    check({tag, "_waddr"},     32'(ram_w_addr), 32'h0);
    check({tag, "_wdata"},     32'(ram_w_data), 32'h0);
    check({tag, "_start_pc"},  32'(start_pc),   32'h0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n),  32'd0);
    check({tag, "_done"},      32'(done),       32'd0);
    check({tag, "_err"},       32'(err),        32'd0);
  endtask

  // Basic frame; start index is the write-log length before it was sent.
  task automatic basic_frame(input string tag, input int gap);
    int base;
    base = wlog.size();
    fr = '{8'hA5, 8'h0F, 8'h02, 8'hD0, 8'h17, 8'hD1, 8'h1E, 8'h0F, 8'h0A};
    send_range(0, 7, gap);
    check({tag, "_pc_before_rel"}, 32'(start_pc),  32'h0F);
    check({tag, "_held"},          32'(cpu_rst_n), 32'd0);
    check({tag, "_done_early"},    32'(done),      32'd0);
    send_range(8, 8, gap);
    check({tag, "_nwr"},       32'(wlog.size() - base), 32'd2);
    check({tag, "_wr0"},       32'(log_at(base)),       32'h0FD017);
    check({tag, "_wr1"},       32'(log_at(base + 1)),   32'h10D11E);
    check({tag, "_done"},      32'(done),      32'd1);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("rst");

    // Basic load
    basic_frame("basic", 0);
    // A byte offered in RUN is not accepted and changes nothing.
    base = wlog.size();
    send_byte(8'hA5);
    repeat (2) @(posedge clk);
    check("run_ignore_done", 32'(done), 32'd1);
    check("run_ignore_nwr",  32'(wlog.size() - base), 32'd0);

    // Reset during RUN re-holds the CPU
    do_reset();
    check_reset_vals("rst_run");

    // Address wrap
    base = wlog.size();
    fr = '{8'hA5, 8'hFF, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'h0A};
    send_range(0, 8, 0);
    check("wrap_nwr", 32'(wlog.size() - base), 32'd2);
    check("wrap_wr0", 32'(log_at(base)),       32'hFF1234);
    check("wrap_wr1", 32'(log_at(base + 1)),   32'h005678);
    check("wrap_pc",   32'(start_pc), 32'hFF);
    check("wrap_done", 32'(done),     32'd1);

    // Bad checksum, then resend
    do_reset();
    base = wlog.size();
    fr = '{8'hA5, 8'h0F, 8'h02, 8'hD0, 8'h17, 8'hD1, 8'h1E, 8'h0F, 8'h0B};
    send_range(0, 8, 0);
    repeat (2) @(posedge clk);
    check("bad_nwr",       32'(wlog.size() - base), 32'd2);
    check("bad_wr0",       32'(log_at(base)),       32'h0FD017);
    check("bad_wr1",       32'(log_at(base + 1)),   32'h10D11E);
    check("bad_err",       32'(err),       32'd1);
    check("bad_done",      32'(done),      32'd0);
    check("bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("bad_in_ready",  32'(in_ready),  32'd1);
    fr = '{8'hA5};
    send_range(0, 0, 0);
    check("bad_err_clr", 32'(err), 32'd0);
    base = wlog.size();
    fr = '{8'hA5, 8'h0F, 8'h02, 8'hD0, 8'h17, 8'hD1, 8'h1E, 8'h0F, 8'h0A};
    send_range(1, 8, 0);
    check("resend_nwr",  32'(wlog.size() - base), 32'd2);
    check("resend_done", 32'(done), 32'd1);
    check("resend_err",  32'(err),  32'd0);

    // Empty program preceded by garbage
    do_reset();
    base = wlog.size();
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'h20, 8'h00};
    send_range(0, 6, 0);
    repeat (2) @(posedge clk);
    check("empty_nwr",  32'(wlog.size() - base), 32'd0);
    check("empty_pc",   32'(start_pc),  32'h20);
    check("empty_done", 32'(done),      32'd1);
    check("empty_rel",  32'(cpu_rst_n), 32'd1);

    // Backpressure gaps
    do_reset();
    basic_frame("gap", 3);

    // Reset mid-frame, then full resend
    do_reset();
    base = wlog.size();
    fr = '{8'hA5, 8'h0F, 8'h02, 8'hD0};
    send_range(0, 3, 0);
    do_reset();
    check_reset_vals("rst_mid");
    check("rst_mid_nwr", 32'(wlog.size() - base), 32'd0);
    basic_frame("after_rst", 0);

    check("strobe_width", 32'(n_wide), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream writer that fills the CPU's instruction/data RAM and then launches the CPU.
- Sits between an external byte source (UART or host bench) and the RAM write port of task3-class CPUs.
- Holds the CPU in reset while loading, drives start_pc, and releases the CPU only after the frame checksum verifies.
- It is the write-side counterpart to the CPU's RAM read path.

Parameters:
- ADDR_W, 8, RAM word-address width; also the start_pc width.
- DATA_W, 16, RAM word width. Fixed at 2 bytes per word, high byte first.
- HDR, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle. A byte is accepted when in_valid && in_ready.
- ram_w_en  out  1  one-cycle RAM write strobe.
- ram_w_addr  out  ADDR_W  RAM write word address.
- ram_w_data  out  DATA_W  RAM write data.
- start_pc  out  ADDR_W  CPU start address.
- cpu_rst_n  out  1  active-low CPU reset; 0 holds the CPU.
- done  out  1  level; program loaded and CPU released.
- err  out  1  level; last frame failed its checksum.

Behaviour:
- Frame format, in byte order:
  - HDR
  - BASE (start word address)
  - CNT (word count, 0..255)
  - 2×CNT data bytes (high byte, then low byte)
  - ENTRY
  - CSUM
- CSUM = XOR of BASE, CNT, all data bytes and ENTRY. HDR is excluded.
- Reset values: state=IDLE, in_ready=1, ram_w_en=0, ram_w_addr=0, ram_w_data=0, start_pc=0, cpu_rst_n=0, done=0, err=0, internal checksum=0.
- States and transitions, each taken on byte acceptance:
  - IDLE: byte==HDR goes to ADDR, clears the checksum and clears err. Any other byte is discarded and the state stays IDLE.
  - ADDR: latch BASE into the write pointer, XOR into the checksum, go to COUNT.
  - COUNT: latch CNT into the remaining counter. CNT==0 goes to ENTRY; otherwise go to DATA_HI.
  - DATA_HI: latch the high byte, go to DATA_LO.
  - DATA_LO: on the next clock, ram_w_en=1 for exactly one cycle, with ram_w_addr=pointer and ram_w_data={hi,lo}. Then increment the pointer modulo 2^ADDR_W (0xFF wraps to 0x00) and decrement remaining. Go to ENTRY if remaining becomes 0, else DATA_HI.
  - ENTRY: register start_pc=ENTRY, go to CSUM.
  - CSUM:
    - Match: go to RUN. cpu_rst_n=1 and done=1 from the following clock.
    - Mismatch: err=1, go to IDLE. cpu_rst_n stays 0; RAM contents already written are not rolled back.
  - RUN: terminal; in_ready=0. Only rst leaves RUN.
- Every byte except HDR updates the checksum by XOR when accepted.
- in_ready=1 in all states except RUN.
- in_valid may drop for any number of cycles inside a frame. State, pointer and checksum hold, and no write occurs.
- start_pc is stable at least 1 cycle before cpu_rst_n rises, which satisfies the CPU's load-PC-in-reset requirement.
- ram_w_en is 0 in all cycles other than the one strobe per DATA_LO acceptance.
- rst mid-frame: all state returns to reset values next clock, cpu_rst_n=0, and partial writes stand. rst during RUN re-holds the CPU.
- A second HDR arriving mid-frame is treated as data. There is no resynchronisation except through a checksum error.

Test Plan:
- Basic load: stream A5,0F,02,D0,17,D1,1E,0F,0A.
  - Writes (0x0F,0xD017) then (0x10,0xD11E).
  - start_pc=0x0F; cpu_rst_n and done rise 1 cycle after CSUM acceptance; err=0; in_ready=0 afterwards.
- Address wrap: A5,FF,02,12,34,56,78,FF,0A.
  - Writes (0xFF,0x1234) then (0x00,0x5678).
  - start_pc=0xFF; done=1.
- Bad checksum: basic frame with CSUM=0B.
  - Both writes occur; err=1; done=0; cpu_rst_n stays 0; state IDLE.
  - Resending the correct frame clears err at HDR and ends with done=1.
- Empty program with garbage: 00,FF,A5,20,00,20,00.
  - Leading 00 and FF are discarded; no ram_w_en pulses.
  - start_pc=0x20; done=1.
- Backpressure gaps: basic frame with in_valid low for 3 cycles between every byte.
  - Identical writes and result; each ram_w_en is exactly 1 cycle wide.
- Reset mid-frame: assert rst after the D0 byte of the basic frame, then resend the full frame.
  - No write occurs before the resend; outputs return to reset values.
  - Final result is the same as the basic load.
